// File: rtl/sirius_issue_pkg.sv
// Shared types for the instruction issue buffer: pre-decode classes, opcode/funct
// constants, the stored entry layout and the lane-pairing hazard check.
package sirius_issue_pkg;

    typedef enum logic [2:0] {
        ALU    = 3'd0,
        MEM    = 3'd1,
        MULDIV = 3'd2,
        BRANCH = 3'd3,
        PRIV   = 3'd4
    } inst_class_t;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_COP0    = 6'b010000;
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_BREAK   = 6'b001101;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;
    localparam logic [4:0] REG_RA     = 5'd31;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        inst_class_t cls;
        logic [4:0]  dest;
        logic [4:0]  src_rs;
        logic [4:0]  src_rt;
    } issue_entry_t;

    // True when older lane j prevents younger lane i from issuing in the same group.
    function automatic logic pair_blocked(input issue_entry_t e_j, input issue_entry_t e_i,
                                          input int j, input int i);
        return (e_j.cls == PRIV) || (e_i.cls == PRIV)
            || ((e_j.cls == MEM) && (e_i.cls == MEM))
            || ((e_j.cls == MULDIV) && (e_i.cls == MULDIV))
            || ((e_j.dest != 5'd0) && ((e_j.dest == e_i.src_rs) || (e_j.dest == e_i.src_rt)))
            || ((e_j.cls == BRANCH) && (i > j + 1));
    endfunction

endpackage

// File: rtl/inst_issue_buffer_predecode.sv
// inst_predecode: combinational classification and register-field extraction
// for one fetched instruction word.
module inst_predecode
    import sirius_issue_pkg::*;
(
    input  logic [31:0] i_inst,
    output inst_class_t o_class,
    output logic [4:0]  o_dest,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic [4:0] w_rd;

    assign w_op = i_inst[31:26];
    assign w_fn = i_inst[5:0];
    assign w_rd = i_inst[15:11];
    assign o_rs = i_inst[25:21];
    assign o_rt = i_inst[20:16];

    // Class in priority order: PRIV, BRANCH, MULDIV, MEM, ALU.
    always_comb begin
        o_class = ALU;
        if ((w_op == OP_COP0) || ((w_op == OP_SPECIAL) && ((w_fn == FN_SYSCALL) || (w_fn == FN_BREAK)))) begin
            o_class = PRIV;
        end else if ((w_op == OP_REGIMM) || (w_op == OP_J) || (w_op == OP_JAL) || (w_op[5:2] == 4'b0001)
                     || ((w_op == OP_SPECIAL) && ((w_fn == FN_JR) || (w_fn == FN_JALR)))) begin
            o_class = BRANCH;
        end else if ((w_op == OP_SPECIAL) && ((w_fn[5:2] == 4'b0110) || (w_fn[5:2] == 4'b0100))) begin
            o_class = MULDIV;
        end else if (w_op[5:4] == 2'b10) begin
            o_class = MEM;
        end else begin
            o_class = ALU;
        end
    end

    // Destination: rd for SPECIAL, $ra for linking branches, rt for I-type ALU and loads.
    always_comb begin
        o_dest = 5'd0;
        if (w_op == OP_SPECIAL) begin
            o_dest = w_rd;
        end else if ((w_op == OP_JAL) || ((w_op == OP_REGIMM) && ((o_rt == RT_BLTZAL) || (o_rt == RT_BGEZAL)))) begin
            o_dest = REG_RA;
        end else if ((w_op[5:3] == 3'b001) || (w_op[5:3] == 3'b100)) begin
            o_dest = o_rt;
        end else begin
            o_dest = 5'd0;
        end
    end

endmodule

// File: rtl/inst_issue_buffer.sv
// Circular fetch-to-decode instruction buffer with hazard-resolved issue groups.
// Optional macro DELAY_SLOT_PAIR_EN: branches issue only in lane 0, together with their delay slot.
module inst_issue_buffer
    import sirius_issue_pkg::*;
#(
    parameter int DEPTH     = 8,
    parameter int IN_WIDTH  = 2,
    parameter int OUT_WIDTH = 2,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [IN_WIDTH-1:0]              in_valid,
    input  logic [IN_WIDTH-1:0][31:0]        in_inst,
    input  logic [IN_WIDTH-1:0][31:0]        in_pc,
    output logic                             in_ready,
    output logic [OUT_WIDTH-1:0]             out_valid,
    output logic [OUT_WIDTH-1:0][31:0]       out_inst,
    output logic [OUT_WIDTH-1:0][31:0]       out_pc,
    output inst_class_t [OUT_WIDTH-1:0]      out_class,
    input  logic [$clog2(OUT_WIDTH+1)-1:0]   out_pop,
    output logic [CNT_W-1:0]                 count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int POP_W = $clog2(OUT_WIDTH + 1);
    localparam int PSH_W = $clog2(IN_WIDTH + 1);
    localparam logic [CNT_W-1:0] READY_MAX = CNT_W'(DEPTH - IN_WIDTH);

`ifdef DELAY_SLOT_PAIR_EN
    if (OUT_WIDTH < 2) begin : g_bad_out_width
        $error("inst_issue_buffer: DELAY_SLOT_PAIR_EN needs OUT_WIDTH >= 2");
    end
`endif

    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    issue_entry_t      r_mem [DEPTH];

    inst_class_t       w_cls  [IN_WIDTH];
    logic [4:0]        w_dest [IN_WIDTH];
    logic [4:0]        w_rs   [IN_WIDTH];
    logic [4:0]        w_rt   [IN_WIDTH];
    issue_entry_t      w_new  [IN_WIDTH];
    logic [PSH_W-1:0]  w_push_off [IN_WIDTH];
    logic [PSH_W-1:0]  w_push_n;
    logic [PSH_W-1:0]  w_push_cnt;
    logic              w_push_en;
    issue_entry_t      w_head_e [OUT_WIDTH];
    logic              w_hold;
    logic              w_lane_ok;
    logic [POP_W-1:0]  w_issue_n;
    logic [POP_W-1:0]  w_pop_n;

    for (genvar g = 0; g < IN_WIDTH; g++) begin : g_pd
        inst_predecode u_pd (
            .i_inst  (in_inst[g]),
            .o_class (w_cls[g]),
            .o_dest  (w_dest[g]),
            .o_rs    (w_rs[g]),
            .o_rt    (w_rt[g])
        );
        assign w_new[g] = '{inst: in_inst[g], pc: in_pc[g], cls: w_cls[g],
                            dest: w_dest[g], src_rs: w_rs[g], src_rt: w_rt[g]};
    end

    assign in_ready   = (r_count <= READY_MAX);
    assign count      = r_count;
    assign w_push_en  = in_ready && !flush;
    assign w_push_cnt = w_push_en ? w_push_n : PSH_W'(0);
    assign w_pop_n    = (out_pop > w_issue_n) ? w_issue_n : out_pop;

    // Each valid lane lands at tail plus the number of valid lanes before it.
    always_comb begin
        w_push_n = PSH_W'(0);
        for (int k = 0; k < IN_WIDTH; k++) begin
            w_push_off[k] = w_push_n;
            w_push_n      = w_push_n + PSH_W'(in_valid[k]);
        end
    end

    // Issue group: prefix of head entries with no pairing hazard against any older lane.
    always_comb begin
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_head_e[i] = r_mem[r_head + PTR_W'(i)];
        end
`ifdef DELAY_SLOT_PAIR_EN
        w_hold = (w_head_e[0].cls == BRANCH) && (r_count < CNT_W'(2));
`else
        w_hold = 1'b0;
`endif
        w_lane_ok = !w_hold;
        w_issue_n = POP_W'(0);
        for (int i = 0; i < OUT_WIDTH; i++) begin
            w_lane_ok = w_lane_ok && (CNT_W'(i) < r_count);
            for (int j = 0; j < OUT_WIDTH; j++) begin
                w_lane_ok = w_lane_ok && ((j >= i) || !pair_blocked(w_head_e[j], w_head_e[i], j, i));
            end
`ifdef DELAY_SLOT_PAIR_EN
            w_lane_ok = w_lane_ok && ((i == 0) || (w_head_e[i].cls != BRANCH));
`endif
            out_valid[i] = w_lane_ok;
            out_inst[i]  = w_head_e[i].inst;
            out_pc[i]    = w_head_e[i].pc;
            out_class[i] = w_head_e[i].cls;
            w_issue_n    = w_issue_n + POP_W'(w_lane_ok);
        end
    end

    // Pointer and occupancy state; flush behaves exactly like reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_head  <= PTR_W'(0);
            r_tail  <= PTR_W'(0);
            r_count <= CNT_W'(0);
        end else begin
            r_head  <= r_head + PTR_W'(w_pop_n);
            r_tail  <= r_tail + PTR_W'(w_push_cnt);
            r_count <= r_count + CNT_W'(w_push_cnt) - CNT_W'(w_pop_n);
        end
    end

    // Entry storage carries no reset; occupancy alone qualifies the contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < IN_WIDTH; k++) begin
            if (!rst && w_push_en && in_valid[k]) begin
                r_mem[r_tail + PTR_W'(w_push_off[k])] <= w_new[k];
            end
        end
    end

endmodule

// File: tb/tb_inst_issue_buffer.sv
// Bench for inst_issue_buffer: directed scenarios then random traffic, all checked
// against a queue-based reference model.
module tb_inst_issue_buffer;
    import sirius_issue_pkg::*;

    localparam int DEPTH = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [1:0]        in_valid;
    logic [1:0][31:0]  in_inst;
    logic [1:0][31:0]  in_pc;
    logic              in_ready;
    logic [1:0]        out_valid;
    logic [1:0][31:0]  out_inst;
    logic [1:0][31:0]  out_pc;
    inst_class_t [1:0] out_class;
    logic [1:0]        out_pop;
    logic [3:0]        count;

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] pc_ctr = 32'h0000_1000;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ment_t;
    ment_t q[$];

    inst_issue_buffer #(.DEPTH(DEPTH), .IN_WIDTH(2), .OUT_WIDTH(2)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_inst(in_inst),
        .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid), .out_inst(out_inst),
        .out_pc(out_pc), .out_class(out_class), .out_pop(out_pop), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rtype(input int rs_f, input int rt_f, input int rd_f, input logic [5:0] fn);
        return {6'd0, 5'(rs_f), 5'(rt_f), 5'(rd_f), 5'd0, fn};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input int rs_f, input int rt_f, input logic [15:0] imm);
        return {op, 5'(rs_f), 5'(rt_f), imm};
    endfunction

    function automatic inst_class_t ref_class(input logic [31:0] w);
        int op = int'(w[31:26]);
        int fn = int'(w[5:0]);
        if (op == 16) return PRIV;
        if (op == 0 && (fn == 12 || fn == 13)) return PRIV;
        if (op >= 1 && op <= 7) return BRANCH;
        if (op == 0 && (fn == 8 || fn == 9)) return BRANCH;
        if (op == 0 && ((fn >= 16 && fn <= 19) || (fn >= 24 && fn <= 27))) return MULDIV;
        if (op >= 32 && op <= 47) return MEM;
        return ALU;
    endfunction

    function automatic int ref_dest(input logic [31:0] w);
        int op = int'(w[31:26]);
        int rt_f = int'(w[20:16]);
        if (op == 0) return int'(w[15:11]);
        if (op == 3 || (op == 1 && (rt_f == 16 || rt_f == 17))) return 31;
        if ((op >= 8 && op <= 15) || (op >= 32 && op <= 39)) return rt_f;
        return 0;
    endfunction

    function automatic bit ref_conflict(input logic [31:0] wj, input logic [31:0] wi, input int j, input int i);
        inst_class_t cj = ref_class(wj);
        inst_class_t ci = ref_class(wi);
        int dj = ref_dest(wj);
        if (cj == PRIV || ci == PRIV) return 1'b1;
        if (cj == ci && (cj == MEM || cj == MULDIV)) return 1'b1;
        if (dj != 0 && (dj == int'(wi[25:21]) || dj == int'(wi[20:16]))) return 1'b1;
        if (cj == BRANCH && i > j + 1) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [1:0] ref_issue();
        logic [1:0] v = 2'b00;
        for (int i = 0; i < 2; i++) begin
            bit ok = (i == 0 || v[i-1] == 1'b1) && (i < q.size());
            for (int j = 0; j < i; j++) begin
                if (ok && ref_conflict(q[j].inst, q[i].inst, j, i)) ok = 1'b0;
            end
`ifdef DELAY_SLOT_PAIR_EN
            if (ok && i > 0 && ref_class(q[i].inst) == BRANCH) ok = 1'b0;
`endif
            v[i] = ok;
        end
`ifdef DELAY_SLOT_PAIR_EN
        if (q.size() == 1 && ref_class(q[0].inst) == BRANCH) v = 2'b00;
`endif
        return v;
    endfunction

    task automatic check_all();
        logic [1:0] ev = ref_issue();
        chk("count", 64'(count), 64'(q.size()));
        chk("in_ready", 64'(in_ready), 64'(q.size() <= DEPTH - 2));
        chk("out_valid", 64'(out_valid), 64'(ev));
        for (int i = 0; i < 2; i++) begin
            if (ev[i]) begin
                chk("out_inst", 64'(out_inst[i]), 64'(q[i].inst));
                chk("out_pc", 64'(out_pc[i]), 64'(q[i].pc));
                chk("out_class", 64'(out_class[i]), 64'(ref_class(q[i].inst)));
            end
        end
    endtask

    // Drive one cycle, advance the model with the pre-edge state, then check after the edge.
    task automatic step(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [1:0] pop, input logic fl, input logic r);
        logic [1:0] ev = ref_issue();
        int pn = (int'(pop) > int'(ev[0]) + int'(ev[1])) ? int'(ev[0]) + int'(ev[1]) : int'(pop);
        bit rdy = (q.size() <= DEPTH - 2);
        in_valid = v; in_inst[0] = i0; in_inst[1] = i1;
        in_pc[0] = pc_ctr; in_pc[1] = pc_ctr + 32'd4;
        out_pop = pop; flush = fl; rst = r;
        if (r || fl) begin
            q.delete();
        end else begin
            for (int k = 0; k < pn; k++) void'(q.pop_front());
            if (rdy && v[0]) q.push_back('{inst: i0, pc: pc_ctr});
            if (rdy && v[1]) q.push_back('{inst: i1, pc: pc_ctr + 32'd4});
        end
        pc_ctr = pc_ctr + 32'd8;
        @(posedge clk);
        #1;
        in_valid = 2'b00; out_pop = 2'b00; flush = 1'b0; rst = 1'b0;
        check_all();
    endtask

    function automatic logic [31:0] rand_inst();
        int a = $urandom_range(0, 7);
        int b = $urandom_range(0, 7);
        int c = $urandom_range(0, 7);
        case ($urandom_range(0, 13))
            0, 1:    return rtype(a, b, c, 6'h21);
            2:       return rtype(a, b, 0, 6'h18);
            3:       return rtype(0, 0, c, 6'h12);
            4:       return itype(6'h23, a, b, 16'h0010);
            5:       return itype(6'h2b, a, b, 16'h0020);
            6:       return itype(6'h09, a, b, 16'h0001);
            7:       return itype(6'h04, a, b, 16'h0003);
            8:       return {6'h03, 26'h0000040};
            9:       return rtype(a, 0, 0, 6'h08);
            10:      return 32'h0000_000C;
            11:      return itype(6'h01, a, 17, 16'h0004);
            12:      return itype(6'h10, 0, b, 16'h0000);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] addu_a, addu_b, subu;
        rst = 1'b1; flush = 1'b0; in_valid = 2'b00; out_pop = 2'b00;
        in_inst = '0; in_pc = '0;
        addu_a = rtype(1, 2, 3, 6'h21);
        addu_b = rtype(5, 6, 4, 6'h21);
        subu   = rtype(3, 4, 5, 6'h23);

        step(2'b00, 32'd0, 32'd0, 2'd0, 1'b0, 1'b1);
        step(2'b00, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_ready", 64'(in_ready), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);

        step(2'b11, addu_a, addu_b, 2'd0, 1'b0, 1'b0);
        chk("alu_pair_valid", 64'(out_valid), 64'b11);
        chk("alu_pair_cls1", 64'(out_class[1]), 64'(ALU));
        step(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("alu_pair_drained", 64'(count), 64'd0);

        step(2'b11, addu_a, subu, 2'd0, 1'b0, 1'b0);
        chk("raw_valid", 64'(out_valid), 64'b01);
        step(2'b00, 32'd0, 32'd0, 2'd1, 1'b0, 1'b0);
        chk("raw_lane0_subu", 64'(out_inst[0]), 64'(subu));
        chk("raw_after_pop", 64'(out_valid), 64'b01);
        step(2'b00, 32'd0, 32'd0, 2'd1, 1'b0, 1'b0);

        step(2'b11, itype(6'h23, 9, 8, 16'h0), itype(6'h2b, 11, 10, 16'h4), 2'd0, 1'b0, 1'b0);
        chk("mem_pair_valid", 64'(out_valid), 64'b01);
        step(2'b00, 32'd0, 32'd0, 2'd1, 1'b0, 1'b0);
        step(2'b00, 32'd0, 32'd0, 2'd1, 1'b0, 1'b0);

        step(2'b11, 32'h0000_000C, addu_b, 2'd0, 1'b0, 1'b0);
        chk("priv_valid", 64'(out_valid), 64'b01);
        chk("priv_class", 64'(out_class[0]), 64'(PRIV));
        step(2'b00, 32'd0, 32'd0, 2'd1, 1'b0, 1'b0);
        step(2'b00, 32'd0, 32'd0, 2'd1, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            step(2'b11, rtype(1, 2, 8 + 2 * k, 6'h21), rtype(1, 2, 9 + 2 * k, 6'h21), 2'd0, 1'b0, 1'b0);
        end
        chk("full_count", 64'(count), 64'd8);
        chk("full_ready", 64'(in_ready), 64'd0);
        step(2'b00, 32'd0, 32'd0, 2'd1, 1'b0, 1'b0);
        chk("seven_ready", 64'(in_ready), 64'd0);
        step(2'b00, 32'd0, 32'd0, 2'd1, 1'b0, 1'b0);
        step(2'b11, rtype(1, 2, 20, 6'h21), rtype(1, 2, 21, 6'h21), 2'd2, 1'b0, 1'b0);
        chk("push_pop_at_six", 64'(count), 64'd6);
        for (int k = 0; k < 3; k++) step(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("wrap_drained", 64'(count), 64'd0);

`ifdef DELAY_SLOT_PAIR_EN
        step(2'b01, itype(6'h04, 1, 2, 16'h3), 32'd0, 2'd0, 1'b0, 1'b0);
        chk("ds_branch_held", 64'(out_valid), 64'b00);
        step(2'b01, addu_b, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("ds_pair_issue", 64'(out_valid), 64'b11);
        step(2'b00, 32'd0, 32'd0, 2'd2, 1'b0, 1'b0);
`endif

        step(2'b11, addu_a, addu_b, 2'd0, 1'b0, 1'b0);
        step(2'b11, addu_a, addu_b, 2'd0, 1'b0, 1'b0);
        step(2'b01, addu_a, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("pre_flush_count", 64'(count), 64'd5);
        step(2'b11, addu_a, addu_b, 2'd1, 1'b1, 1'b0);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'b00);

        step(2'b11, addu_a, addu_b, 2'd0, 1'b0, 1'b0);
        step(2'b11, addu_a, addu_b, 2'd1, 1'b1, 1'b1);
        chk("reset_mid_count", 64'(count), 64'd0);

        for (int n = 0; n < 800; n++) begin
            logic [1:0] ev = ref_issue();
            logic [1:0] v = 2'b00;
            int lanes = $urandom_range(0, 2);
            if (q.size() <= DEPTH - 2) v = (lanes == 0) ? 2'b00 : ((lanes == 1) ? 2'b01 : 2'b11);
            step(v, rand_inst(), rand_inst(), 2'($urandom_range(0, int'(ev[0]) + int'(ev[1]))),
                 ($urandom_range(0, 39) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
